// File: rtl/dsp_rd_channel_pkg.sv
// Shared definitions for the read-channel dispatcher.
// Holds the default bus widths and a helper that pulls one slot out of a packed per-arbiter bus.
package dsp_rd_channel_pkg;

  localparam int DEF_SLV_AMT          = 2;
  localparam int DEF_OUTSTANDING_AMT  = 8;
  localparam int DEF_DATA_WIDTH       = 32;
  localparam int DEF_ADDR_WIDTH       = 32;
  localparam int DEF_MST_ID_W         = 5;
  localparam int DEF_BURST_W          = 2;
  localparam int DEF_DATA_LEN_W       = 3;
  localparam int DEF_DATA_SIZE_W      = 3;
  localparam int DEF_WR_RESP_W        = 2;
  localparam int DEF_SLV_ID_MSB_IDX   = 30;
  localparam int DEF_SLV_ID_LSB_IDX   = 30;

  // Widest packed bus the slot helper accepts and widest slot it returns.
  localparam int SLOT_BUS_W = 512;
  localparam int SLOT_W     = 64;

  // Returns slot idx (width bits) of a packed bus where slot i sits at [width*(i+1)-1 -: width].
  // Callers zero-extend their bus to SLOT_BUS_W and truncate the result to their own width.
  function automatic logic [SLOT_W-1:0] getSlot(input logic [SLOT_BUS_W-1:0] bus,
                                                input int idx,
                                                input int width);
    logic [SLOT_W-1:0] mask;
    mask = (width >= SLOT_W) ? '1 : ((SLOT_W'(1) << width) - SLOT_W'(1));
    return SLOT_W'(bus >> (idx * width)) & mask;
  endfunction

endpackage

// File: rtl/dsp_rd_order_fifo.sv
// Ordering FIFO of the read dispatcher.
// Remembers which slave arbiter each accepted AR went to, oldest entry at the head.
module dsp_rd_order_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_pushData,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;

  logic             w_doPush;
  logic             w_doPop;
  logic [PTR_W-1:0] w_wrPtrNext;
  logic [PTR_W-1:0] w_rdPtrNext;

  // A push while full or a pop while empty is dropped rather than corrupting the pointers.
  assign w_doPush = i_push & ~o_full;
  assign w_doPop  = i_pop & ~o_empty;

  assign w_wrPtrNext = (r_wrPtr == PTR_W'(DEPTH - 1)) ? '0 : r_wrPtr + PTR_W'(1);
  assign w_rdPtrNext = (r_rdPtr == PTR_W'(DEPTH - 1)) ? '0 : r_rdPtr + PTR_W'(1);

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rdPtr];

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge i_clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_pushData;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= w_wrPtrNext;
      end
      if (w_doPop) begin
        r_rdPtr <= w_rdPtrNext;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dsp_rd_channel.sv
// AXI4 read-channel dispatcher for one master port.
// Routes each AR to the slave arbiter picked by the address and hands R beats back in AR issue order.
module dsp_rd_channel
  import dsp_rd_channel_pkg::*;
#(
  parameter int SLV_AMT           = DEF_SLV_AMT,
  parameter int OUTSTANDING_AMT   = DEF_OUTSTANDING_AMT,
  parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH        = DEF_ADDR_WIDTH,
  parameter int TRANS_MST_ID_W    = DEF_MST_ID_W,
  parameter int TRANS_BURST_W     = DEF_BURST_W,
  parameter int TRANS_DATA_LEN_W  = DEF_DATA_LEN_W,
  parameter int TRANS_DATA_SIZE_W = DEF_DATA_SIZE_W,
  parameter int TRANS_WR_RESP_W   = DEF_WR_RESP_W,
  parameter int SLV_ID_W          = $clog2(SLV_AMT),
  parameter int SLV_ID_MSB_IDX    = DEF_SLV_ID_MSB_IDX,
  parameter int SLV_ID_LSB_IDX    = DEF_SLV_ID_LSB_IDX
) (
  input  logic                                   ACLK_i,
  input  logic                                   ARESET_i,
  // Master AR
  input  logic [TRANS_MST_ID_W-1:0]              m_ARID_i,
  input  logic [ADDR_WIDTH-1:0]                  m_ARADDR_i,
  input  logic [TRANS_BURST_W-1:0]               m_ARBURST_i,
  input  logic [TRANS_DATA_LEN_W-1:0]            m_ARLEN_i,
  input  logic [TRANS_DATA_SIZE_W-1:0]           m_ARSIZE_i,
  input  logic                                   m_ARVALID_i,
  output logic                                   m_ARREADY_o,
  // Master R
  output logic [TRANS_MST_ID_W-1:0]              m_RID_o,
  output logic [DATA_WIDTH-1:0]                  m_RDATA_o,
  output logic                                   m_RLAST_o,
  output logic                                   m_RVALID_o,
  input  logic                                   m_RREADY_i,
  // Slave-arbiter AR
  output logic [TRANS_MST_ID_W*SLV_AMT-1:0]      sa_ARID_o,
  output logic [ADDR_WIDTH*SLV_AMT-1:0]          sa_ARADDR_o,
  output logic [TRANS_BURST_W*SLV_AMT-1:0]       sa_ARBURST_o,
  output logic [TRANS_DATA_LEN_W*SLV_AMT-1:0]    sa_ARLEN_o,
  output logic [TRANS_DATA_SIZE_W*SLV_AMT-1:0]   sa_ARSIZE_o,
  output logic [SLV_AMT-1:0]                     sa_ARVALID_o,
  input  logic [SLV_AMT-1:0]                     sa_ARREADY_i,
  output logic [SLV_AMT-1:0]                     sa_AR_outst_full_o,
  // Slave-arbiter R
  input  logic [TRANS_MST_ID_W*SLV_AMT-1:0]      sa_RID_i,
  input  logic [DATA_WIDTH*SLV_AMT-1:0]          sa_RDATA_i,
  input  logic [SLV_AMT-1:0]                     sa_RLAST_i,
  input  logic [SLV_AMT-1:0]                     sa_RVALID_i,
  output logic [SLV_AMT-1:0]                     sa_RREADY_o
);

  localparam int DEC_W = SLV_ID_MSB_IDX - SLV_ID_LSB_IDX + 1;

  logic [DEC_W-1:0]    w_decRaw;
  logic [SLV_ID_W-1:0] w_sel;
  logic [SLV_ID_W-1:0] w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_arBlocked;
  logic                w_push;
  logic                w_pop;

  // The write-response width plays no part on the read path; it is only carried so that
  // every dispatcher instance shares one parameter list.
  if (TRANS_WR_RESP_W < 1) begin : g_wrRespWidthUnused
  end

  // Slave index comes straight from the address field; out-of-range indices fold back.
  assign w_decRaw = m_ARADDR_i[SLV_ID_MSB_IDX:SLV_ID_LSB_IDX];
  assign w_sel    = SLV_ID_W'(32'(w_decRaw) % SLV_AMT);

  // A full ordering FIFO or an active reset stops new ARs; a same-cycle pop does not bypass this.
  assign w_arBlocked = w_full | ARESET_i;

  // Every arbiter sees the master payload; only the selected one sees VALID.
  assign sa_ARID_o    = {SLV_AMT{m_ARID_i}};
  assign sa_ARADDR_o  = {SLV_AMT{m_ARADDR_i}};
  assign sa_ARBURST_o = {SLV_AMT{m_ARBURST_i}};
  assign sa_ARLEN_o   = {SLV_AMT{m_ARLEN_i}};
  assign sa_ARSIZE_o  = {SLV_AMT{m_ARSIZE_i}};

  assign m_ARREADY_o        = sa_ARREADY_i[w_sel] & ~w_arBlocked;
  assign sa_AR_outst_full_o = {SLV_AMT{w_full}};

  // Demux the master AR valid onto the selected arbiter.
  always_comb begin
    sa_ARVALID_o = '0;
    if (m_ARVALID_i && !w_arBlocked) begin
      sa_ARVALID_o[w_sel] = 1'b1;
    end
  end

  // Record the destination of every accepted AR; retire it on the last R beat of that burst.
  assign w_push = m_ARVALID_i & m_ARREADY_o;
  assign w_pop  = m_RVALID_o & m_RREADY_i & m_RLAST_o;

  dsp_rd_order_fifo #(
    .WIDTH (SLV_ID_W),
    .DEPTH (OUTSTANDING_AMT)
  ) u_orderFifo (
    .i_clk      (ACLK_i),
    .i_reset    (ARESET_i),
    .i_push     (w_push),
    .i_pushData (w_sel),
    .i_pop      (w_pop),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_head     (w_head)
  );

  // Only the arbiter owning the oldest outstanding burst may talk to the master; others stall.
  always_comb begin
    m_RVALID_o  = 1'b0;
    m_RID_o     = '0;
    m_RDATA_o   = '0;
    m_RLAST_o   = 1'b0;
    sa_RREADY_o = '0;
    if (!w_empty) begin
      m_RVALID_o          = sa_RVALID_i[w_head];
      m_RLAST_o           = sa_RLAST_i[w_head];
      m_RID_o             = TRANS_MST_ID_W'(getSlot(SLOT_BUS_W'(sa_RID_i), int'(w_head), TRANS_MST_ID_W));
      m_RDATA_o           = DATA_WIDTH'(getSlot(SLOT_BUS_W'(sa_RDATA_i), int'(w_head), DATA_WIDTH));
      sa_RREADY_o[w_head] = m_RREADY_i;
    end
  end

endmodule

// File: tb/tb_dsp_rd_channel.sv
// Testbench for dsp_rd_channel: directed table, hand-written corner sequences and a randomized run
// checked against a queue-based model of issue order.
module tb_dsp_rd_channel;

  localparam int SLV = 2;
  localparam int OUT = 8;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int IDW = 5;
  localparam int BW  = 2;
  localparam int LW  = 3;
  localparam int SW  = 3;

  logic              ACLK_i = 1'b0;
  logic              ARESET_i;
  logic [IDW-1:0]    m_ARID_i;
  logic [AW-1:0]     m_ARADDR_i;
  logic [BW-1:0]     m_ARBURST_i;
  logic [LW-1:0]     m_ARLEN_i;
  logic [SW-1:0]     m_ARSIZE_i;
  logic              m_ARVALID_i;
  logic              m_ARREADY_o;
  logic [IDW-1:0]    m_RID_o;
  logic [DW-1:0]     m_RDATA_o;
  logic              m_RLAST_o;
  logic              m_RVALID_o;
  logic              m_RREADY_i;
  logic [IDW*SLV-1:0] sa_ARID_o;
  logic [AW*SLV-1:0]  sa_ARADDR_o;
  logic [BW*SLV-1:0]  sa_ARBURST_o;
  logic [LW*SLV-1:0]  sa_ARLEN_o;
  logic [SW*SLV-1:0]  sa_ARSIZE_o;
  logic [SLV-1:0]     sa_ARVALID_o;
  logic [SLV-1:0]     sa_ARREADY_i;
  logic [SLV-1:0]     sa_AR_outst_full_o;
  logic [IDW*SLV-1:0] sa_RID_i;
  logic [DW*SLV-1:0]  sa_RDATA_i;
  logic [SLV-1:0]     sa_RLAST_i;
  logic [SLV-1:0]     sa_RVALID_i;
  logic [SLV-1:0]     sa_RREADY_o;

  int vectorCount = 0;
  int missCount   = 0;
  int orderQ[$];

  always #5 ACLK_i = ~ACLK_i;

  dsp_rd_channel dut (
    .ACLK_i             (ACLK_i),
    .ARESET_i           (ARESET_i),
    .m_ARID_i           (m_ARID_i),
    .m_ARADDR_i         (m_ARADDR_i),
    .m_ARBURST_i        (m_ARBURST_i),
    .m_ARLEN_i          (m_ARLEN_i),
    .m_ARSIZE_i         (m_ARSIZE_i),
    .m_ARVALID_i        (m_ARVALID_i),
    .m_ARREADY_o        (m_ARREADY_o),
    .m_RID_o            (m_RID_o),
    .m_RDATA_o          (m_RDATA_o),
    .m_RLAST_o          (m_RLAST_o),
    .m_RVALID_o         (m_RVALID_o),
    .m_RREADY_i         (m_RREADY_i),
    .sa_ARID_o          (sa_ARID_o),
    .sa_ARADDR_o        (sa_ARADDR_o),
    .sa_ARBURST_o       (sa_ARBURST_o),
    .sa_ARLEN_o         (sa_ARLEN_o),
    .sa_ARSIZE_o        (sa_ARSIZE_o),
    .sa_ARVALID_o       (sa_ARVALID_o),
    .sa_ARREADY_i       (sa_ARREADY_i),
    .sa_AR_outst_full_o (sa_AR_outst_full_o),
    .sa_RID_i           (sa_RID_i),
    .sa_RDATA_i         (sa_RDATA_i),
    .sa_RLAST_i         (sa_RLAST_i),
    .sa_RVALID_i        (sa_RVALID_i),
    .sa_RREADY_o        (sa_RREADY_o)
  );

  typedef struct {
    logic [AW-1:0]  araddr;
    logic           arvalid;
    logic [1:0]     arready;
    logic [1:0]     rvalid;
    logic [1:0]     rlast;
    logic [IDW-1:0] rid0;
    logic [IDW-1:0] rid1;
    logic           rready;
    logic [1:0]     expSaArvalid;
    logic           expArready;
    logic           expRvalid;
    logic [IDW-1:0] expRid;
    logic           expRlast;
    logic [1:0]     expSaRready;
    logic [1:0]     expFull;
  } vec_t;

  vec_t vecs[13];

  // One comparison; counts it and reports a FAIL line on mismatch.
  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectorCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive the master/arbiter inputs for one cycle.
  task automatic applyStimulus(input logic [AW-1:0] addr, input logic arvalid, input logic [1:0] arready,
                               input logic [1:0] rvalid, input logic [1:0] rlast,
                               input logic [IDW-1:0] rid0, input logic [IDW-1:0] rid1,
                               input logic [DW*SLV-1:0] rdata, input logic rready);
    m_ARADDR_i   = addr;
    m_ARVALID_i  = arvalid;
    sa_ARREADY_i = arready;
    sa_RVALID_i  = rvalid;
    sa_RLAST_i   = rlast;
    sa_RID_i     = {rid1, rid0};
    sa_RDATA_i   = rdata;
    m_RREADY_i   = rready;
  endtask

  // Slave index: address bit 30, folded into the number of slaves.
  function automatic int selOf(input logic [AW-1:0] a);
    return int'((a >> 30) & 32'd1) % SLV;
  endfunction

  // Compare every DUT output with what the issue-order queue says it should be.
  task automatic checkModel(input string tag);
    logic        full;
    int          sel;
    int          h;
    logic [1:0]  expArv;
    logic        expArr;
    logic        expRv;
    logic [IDW-1:0] expRid;
    logic [DW-1:0]  expRdata;
    logic        expRl;
    logic [1:0]  expRr;
    full   = (orderQ.size() == OUT);
    sel    = selOf(m_ARADDR_i);
    expArv = 2'b00;
    if (m_ARVALID_i && !full && !ARESET_i) expArv[sel] = 1'b1;
    expArr = sa_ARREADY_i[sel] && !full && !ARESET_i;
    expRv = 1'b0; expRid = '0; expRdata = '0; expRl = 1'b0; expRr = 2'b00;
    if (orderQ.size() > 0) begin
      h        = orderQ[0];
      expRv    = sa_RVALID_i[h];
      expRid   = sa_RID_i[h*IDW +: IDW];
      expRdata = sa_RDATA_i[h*DW +: DW];
      expRl    = sa_RLAST_i[h];
      expRr[h] = m_RREADY_i;
    end
    checkVal({tag, ".saArvalid"}, 64'(sa_ARVALID_o), 64'(expArv));
    checkVal({tag, ".mArready"},  64'(m_ARREADY_o), 64'(expArr));
    checkVal({tag, ".full"},      64'(sa_AR_outst_full_o), 64'(full ? 2'b11 : 2'b00));
    checkVal({tag, ".mRvalid"},   64'(m_RVALID_o), 64'(expRv));
    checkVal({tag, ".mRid"},      64'(m_RID_o), 64'(expRid));
    checkVal({tag, ".mRdata"},    64'(m_RDATA_o), 64'(expRdata));
    checkVal({tag, ".mRlast"},    64'(m_RLAST_o), 64'(expRl));
    checkVal({tag, ".saRready"},  64'(sa_RREADY_o), 64'(expRr));
    checkVal({tag, ".saAraddr"},  64'(sa_ARADDR_o), {m_ARADDR_i, m_ARADDR_i});
    checkVal({tag, ".saArid"},    64'(sa_ARID_o), 64'({m_ARID_i, m_ARID_i}));
    checkVal({tag, ".saArlen"},   64'(sa_ARLEN_o), 64'({m_ARLEN_i, m_ARLEN_i}));
  endtask

  // Advance the order model by one clock edge using the inputs present at that edge.
  task automatic commitModel();
    logic full;
    int   sel;
    logic popOk;
    logic pushOk;
    if (ARESET_i) begin
      orderQ.delete();
    end else begin
      full   = (orderQ.size() == OUT);
      sel    = selOf(m_ARADDR_i);
      popOk  = (orderQ.size() > 0) && sa_RVALID_i[orderQ[0]] && m_RREADY_i && sa_RLAST_i[orderQ[0]];
      pushOk = m_ARVALID_i && sa_ARREADY_i[sel] && !full;
      if (popOk)  void'(orderQ.pop_front());
      if (pushOk) orderQ.push_back(sel);
    end
  endtask

  task automatic finishCycle();
    @(posedge ACLK_i);
    commitModel();
    #1;
  endtask

  // Compare one table row against its hand-derived expectations.
  task automatic checkOutput(input vec_t v, input int idx);
    string t;
    t = $sformatf("row%0d", idx);
    checkVal({t, ".saArvalid"}, 64'(sa_ARVALID_o), 64'(v.expSaArvalid));
    checkVal({t, ".mArready"},  64'(m_ARREADY_o), 64'(v.expArready));
    checkVal({t, ".mRvalid"},   64'(m_RVALID_o), 64'(v.expRvalid));
    checkVal({t, ".mRid"},      64'(m_RID_o), 64'(v.expRid));
    checkVal({t, ".mRlast"},    64'(m_RLAST_o), 64'(v.expRlast));
    checkVal({t, ".saRready"},  64'(sa_RREADY_o), 64'(v.expSaRready));
    checkVal({t, ".full"},      64'(sa_AR_outst_full_o), 64'(v.expFull));
  endtask

  initial begin
    //          addr          arv ardy  rv     rl     rid0   rid1   rrdy  saArv arr rv rid    rl  saRr   full
    vecs[0]  = '{32'h0000_0000, 0, 2'b00, 2'b00, 2'b00, 5'd0,  5'd0,  0, 2'b00, 0, 0, 5'd0,  0, 2'b00, 2'b00};
    vecs[1]  = '{32'h0000_0000, 1, 2'b11, 2'b00, 2'b00, 5'd0,  5'd0,  0, 2'b01, 1, 0, 5'd0,  0, 2'b00, 2'b00};
    vecs[2]  = '{32'h4000_001E, 1, 2'b11, 2'b00, 2'b00, 5'd0,  5'd0,  0, 2'b10, 1, 0, 5'd0,  0, 2'b00, 2'b00};
    vecs[3]  = '{32'h4000_0028, 1, 2'b11, 2'b00, 2'b00, 5'd0,  5'd0,  0, 2'b10, 1, 0, 5'd0,  0, 2'b00, 2'b00};
    vecs[4]  = '{32'h0000_0028, 1, 2'b11, 2'b00, 2'b00, 5'd0,  5'd0,  0, 2'b01, 1, 0, 5'd0,  0, 2'b00, 2'b00};
    vecs[5]  = '{32'h0000_0000, 0, 2'b00, 2'b10, 2'b10, 5'd3,  5'd10, 1, 2'b00, 0, 0, 5'd3,  0, 2'b01, 2'b00};
    vecs[6]  = '{32'h0000_0000, 0, 2'b00, 2'b11, 2'b11, 5'd3,  5'd10, 1, 2'b00, 0, 1, 5'd3,  1, 2'b01, 2'b00};
    vecs[7]  = '{32'h0000_0000, 0, 2'b00, 2'b10, 2'b00, 5'd3,  5'd11, 1, 2'b00, 0, 1, 5'd11, 0, 2'b10, 2'b00};
    vecs[8]  = '{32'h0000_0000, 0, 2'b00, 2'b10, 2'b00, 5'd3,  5'd11, 0, 2'b00, 0, 1, 5'd11, 0, 2'b00, 2'b00};
    vecs[9]  = '{32'h0000_0000, 0, 2'b00, 2'b10, 2'b10, 5'd3,  5'd11, 1, 2'b00, 0, 1, 5'd11, 1, 2'b10, 2'b00};
    vecs[10] = '{32'h0000_0000, 0, 2'b00, 2'b10, 2'b10, 5'd3,  5'd12, 1, 2'b00, 0, 1, 5'd12, 1, 2'b10, 2'b00};
    vecs[11] = '{32'h0000_0000, 0, 2'b00, 2'b01, 2'b01, 5'd5,  5'd12, 1, 2'b00, 0, 1, 5'd5,  1, 2'b01, 2'b00};
    vecs[12] = '{32'h0000_0000, 0, 2'b00, 2'b11, 2'b11, 5'd7,  5'd9,  1, 2'b00, 0, 0, 5'd0,  0, 2'b00, 2'b00};

    m_ARID_i    = 5'd4;
    m_ARBURST_i = 2'b01;
    m_ARLEN_i   = 3'd0;
    m_ARSIZE_i  = 3'd2;
    ARESET_i    = 1'b1;
    applyStimulus(32'h0, 1'b1, 2'b11, 2'b00, 2'b00, 5'd0, 5'd0, '0, 1'b0);

    // Reset: AR blocked while reset is asserted.
    @(posedge ACLK_i); #1;
    finishCycle();
    #2;
    checkVal("rst.mArready",  64'(m_ARREADY_o), 64'd0);
    checkVal("rst.saArvalid", 64'(sa_ARVALID_o), 64'd0);
    finishCycle();
    ARESET_i = 1'b0;

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].araddr, vecs[i].arvalid, vecs[i].arready, vecs[i].rvalid, vecs[i].rlast,
                    vecs[i].rid0, vecs[i].rid1, {27'd0, vecs[i].rid1, 27'd0, vecs[i].rid0}, vecs[i].rready);
      #2;
      checkOutput(vecs[i], i);
      finishCycle();
    end

    // Fill the ordering FIFO with no R traffic.
    for (int i = 0; i < OUT; i++) begin
      applyStimulus((i % 2) ? 32'h4000_0000 : 32'h0, 1'b1, 2'b11, 2'b00, 2'b00, 5'd0, 5'd0, '0, 1'b1);
      #2;
      checkModel($sformatf("fill%0d", i));
      checkVal($sformatf("fill%0d.ready", i), 64'(m_ARREADY_o), 64'd1);
      finishCycle();
    end
    applyStimulus(32'h0, 1'b1, 2'b11, 2'b00, 2'b00, 5'd0, 5'd0, '0, 1'b1);
    #2;
    checkVal("full.flag",      64'(sa_AR_outst_full_o), 64'd3);
    checkVal("full.mArready",  64'(m_ARREADY_o), 64'd0);
    checkVal("full.saArvalid", 64'(sa_ARVALID_o), 64'd0);
    finishCycle();

    // A pop in the same cycle must not let a new AR through.
    applyStimulus(32'h0, 1'b1, 2'b11, 2'b01, 2'b01, 5'd2, 5'd0, 64'h0000_0000_1234_5678, 1'b1);
    #2;
    checkModel("popFull");
    checkVal("popFull.mArready", 64'(m_ARREADY_o), 64'd0);
    checkVal("popFull.mRvalid",  64'(m_RVALID_o), 64'd1);
    finishCycle();
    applyStimulus(32'h0, 1'b1, 2'b11, 2'b00, 2'b00, 5'd0, 5'd0, '0, 1'b1);
    #2;
    checkModel("afterPop");
    checkVal("afterPop.full",     64'(sa_AR_outst_full_o), 64'd0);
    checkVal("afterPop.mArready", 64'(m_ARREADY_o), 64'd1);
    finishCycle();

    // Reset with bursts outstanding drops the order.
    ARESET_i = 1'b1;
    applyStimulus(32'h4000_0000, 1'b1, 2'b11, 2'b11, 2'b11, 5'd1, 5'd2, '0, 1'b1);
    #2;
    checkVal("midRst.mArready",  64'(m_ARREADY_o), 64'd0);
    checkVal("midRst.saArvalid", 64'(sa_ARVALID_o), 64'd0);
    finishCycle();
    ARESET_i = 1'b0;
    applyStimulus(32'h0, 1'b0, 2'b11, 2'b11, 2'b11, 5'd1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    #2;
    checkModel("postRst");
    checkVal("postRst.full",     64'(sa_AR_outst_full_o), 64'd0);
    checkVal("postRst.mRvalid",  64'(m_RVALID_o), 64'd0);
    checkVal("postRst.saRready", 64'(sa_RREADY_o), 64'd0);
    finishCycle();

    // Randomized traffic against the issue-order model.
    for (int n = 0; n < 800; n++) begin
      ARESET_i    = ($urandom_range(0, 99) == 0);
      m_ARID_i    = IDW'($urandom);
      m_ARBURST_i = BW'($urandom);
      m_ARLEN_i   = LW'($urandom);
      m_ARSIZE_i  = SW'($urandom);
      applyStimulus($urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)),
                    {($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3)},
                    IDW'($urandom), IDW'($urandom), {$urandom, $urandom},
                    ($urandom_range(0, 9) < 7));
      #2;
      checkModel($sformatf("rnd%0d", n));
      finishCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
